// File: rtl/ram_arbiter.sv
// Shares the single-port main RAM between the CPU (owns every cpu_clken cycle plus the guard cycles before it) and a DMA requester.
// Optional CPU halt support is enabled by defining RAM_ARBITER_HALT_EN.
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int CLKEN_DIV = 25,
    parameter int ADDR_W    = 13
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              cpu_clken,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic              cpu_ram_cs,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dbo,
    output logic [7:0]        cpu_ram_dout,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_din,
`ifdef RAM_ARBITER_HALT_EN
    input  logic              dma_halt,
`endif
    output logic              dma_ack,
    output logic [7:0]        dma_dout,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_w_en,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    localparam int PW = $clog2(CLKEN_DIV);
    localparam logic [PW-1:0] PHASE_MAX      = PW'(CLKEN_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST_DMA = PW'(CLKEN_DIV - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic [PW-1:0]     phase;
    logic              phase_ok;
    logic              halted;
    logic              window;
    logic              dma_slot;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_din;
    logic [7:0]        dout_q;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            phase_ok <= 1'b0;
        end else if (cpu_clken) begin
            phase    <= '0;
            phase_ok <= 1'b1;
        end else if (phase != PHASE_MAX) begin
            phase    <= phase + 1'b1;
        end
    end

`ifdef RAM_ARBITER_HALT_EN
    // Halt state only changes on CPU enables so the CPU never sees a partial cycle.
    logic ready_q;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else if (cpu_clken) begin
            ready_q <= !dma_halt;
        end
    end

    assign cpu_ready = ready_q;
    assign halted    = !ready_q;
`else
    assign cpu_ready = 1'b1;
    assign halted    = 1'b0;
`endif

    assign window = phase_ok && !cpu_clken && (halted || (phase <= PHASE_LAST_DMA));

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dma_req && window) state_next = ACCESS;
            ACCESS:  state_next = cpu_clken ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The request is captured on entry so a requester dropping dma_req early cannot disturb the access.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            req_we   <= 1'b0;
            req_addr <= '0;
            req_din  <= '0;
        end else if ((state == IDLE) && (state_next == ACCESS)) begin
            req_we   <= dma_we;
            req_addr <= dma_addr;
            req_din  <= dma_din;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            dout_q <= 8'h00;
        end else if ((state == RESP) && !req_we) begin
            dout_q <= ram_dout;
        end
    end

    assign dma_slot     = (state == ACCESS) && !cpu_clken;
    assign ram_address  = dma_slot ? req_addr : cpu_ab;
    assign ram_din      = dma_slot ? req_din : cpu_dbo;
    assign ram_w_en     = dma_slot ? req_we : (cpu_we & cpu_ram_cs & cpu_clken);
    assign cpu_ram_dout = ram_dout;
    assign dma_ack      = (state == RESP);
    assign dma_dout     = ((state == RESP) && !req_we) ? ram_dout : dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a behavioural RAM plus a timing/contents model derived from the clken schedule.
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int PER = 25;
    localparam int AW  = 13;
    localparam int BIG = 1 << 30;

    logic          clk25 = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_clken = 1'b0;
    logic [AW-1:0] cpu_ab = '0;
    logic          cpu_ram_cs = 1'b0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_dbo = 8'h00;
    logic [7:0]    cpu_ram_dout;
    logic          cpu_ready;
    logic          dma_req = 1'b0;
    logic          dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [7:0]    dma_din = 8'h00;
    logic          dma_ack;
    logic [7:0]    dma_dout;
    logic [AW-1:0] ram_address;
    logic          ram_w_en;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout = 8'h00;
`ifdef RAM_ARBITER_HALT_EN
    logic          dma_halt = 1'b0;
`endif

    logic [7:0] mem    [0:(1<<AW)-1] = '{default: 8'h00};
    logic [7:0] shadow [0:(1<<AW)-1] = '{default: 8'h00};

    int         cyc = 0;
    int         firstClk = BIG;
    int         assertCount = 0;
    int         failCount = 0;
    int         cpuCount = 0;
    int         pred = 0;
    bit         pending = 1'b0;
    logic [7:0] lastDout = 8'h00;
    logic          reqWe;
    logic [AW-1:0] reqAddr;
    logic [7:0]    reqDin;

    ram_arbiter #(.CLKEN_DIV(PER), .ADDR_W(AW)) dut (
        .clk25(clk25), .rst(rst), .cpu_clken(cpu_clken), .cpu_ab(cpu_ab),
        .cpu_ram_cs(cpu_ram_cs), .cpu_we(cpu_we), .cpu_dbo(cpu_dbo),
        .cpu_ram_dout(cpu_ram_dout), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
`ifdef RAM_ARBITER_HALT_EN
        .dma_halt(dma_halt),
`endif
        .dma_ack(dma_ack), .dma_dout(dma_dout), .ram_address(ram_address),
        .ram_w_en(ram_w_en), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #20 clk25 = ~clk25;

    // Single-port synchronous RAM, read-before-write.
    always @(posedge clk25) begin
        if (ram_w_en) mem[ram_address] <= ram_din;
        ram_dout <= mem[ram_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit clkenAt(input int k);
        return (k >= firstClk) && (((k - firstClk) % PER) == 0);
    endfunction

    function automatic int phaseOf(input int k);
        if (k <= firstClk) return -1;
        return (k - 1 - firstClk) % PER;
    endfunction

    function automatic bit dmaWindow(input int k);
        int ph;
        ph = phaseOf(k);
        return (ph >= 0) && (ph <= PER - 4) && !clkenAt(k);
    endfunction

    // Ack comes two cycles after the first idle window cycle, unless a CPU enable lands on the access cycle.
    function automatic int predictAck(input int t);
        for (int k = t; k < t + 4 * PER; k++) begin
            if (dmaWindow(k) && !clkenAt(k + 1)) return k + 2;
        end
        return t + 4 * PER;
    endfunction

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(0, 4))
            0:       return AW'(13'h0200);
            1:       return AW'(13'h0300);
            2:       return AW'(13'h1FFF);
            3:       return AW'(13'h0000);
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic pickCpu();
        if (cpuCount == 0) begin
            cpu_ram_cs = 1'b1; cpu_we = 1'b1; cpu_ab = AW'(13'h0200); cpu_dbo = 8'hA5;
        end else if (cpuCount == 1) begin
            cpu_ram_cs = 1'b1; cpu_we = 1'b0; cpu_ab = AW'(13'h0200); cpu_dbo = 8'h00;
        end else begin
            cpu_ram_cs = ($urandom_range(0, 9) != 0);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_ab     = pickAddr();
            cpu_dbo    = 8'($urandom);
        end
        cpuCount++;
    endtask

    // One clock cycle: drive this cycle's CPU inputs, then check every output against the model.
    task automatic applyStimulus();
        bit expAck;
        @(posedge clk25);
        #1;
        cyc++;
        cpu_clken = clkenAt(cyc);
        if (clkenAt(cyc - 1)) pickCpu();
        #2;
        expAck = pending && (cyc == pred);
        checkOutput("dma_ack", 32'(dma_ack), 32'(expAck));
        if (expAck) begin
            if (reqWe) shadow[reqAddr] = reqDin;
            else       lastDout = shadow[reqAddr];
            pending = 1'b0;
            dma_req = 1'b0;
        end
        checkOutput("dma_dout", 32'(dma_dout), 32'(lastDout));
        if (cpu_clken) begin
            checkOutput("cpu_ready", 32'(cpu_ready), 32'd1);
            if (cpu_ram_cs && !cpu_we) checkOutput("cpu_rd", 32'(cpu_ram_dout), 32'(shadow[cpu_ab]));
            if (cpu_ram_cs && cpu_we) shadow[cpu_ab] = cpu_dbo;
        end
    endtask

    task automatic issueDma(input logic we, input logic [AW-1:0] addr, input logic [7:0] din);
        reqWe = we; reqAddr = addr; reqDin = din;
        dma_we = we; dma_addr = addr; dma_din = din; dma_req = 1'b1;
        pending = 1'b1;
        pred = predictAck(cyc);
    endtask

    task automatic waitDone();
        for (int w = 0; w < 4 * PER && pending; w++) applyStimulus();
        if (pending) begin
            checkOutput("dma_timeout", 32'd0, 32'd1);
            pending = 1'b0;
            dma_req = 1'b0;
        end
    endtask

    task automatic waitPhase(input int tgt);
        for (int w = 0; w < PER + 1 && phaseOf(cyc) != tgt; w++) applyStimulus();
    endtask

    task automatic runOps(input int n);
        for (int i = 0; i < n; i++) begin
            waitPhase($urandom_range(0, PER - 1));
            issueDma(1'($urandom_range(0, 1)), pickAddr(), 8'($urandom));
            waitDone();
            applyStimulus();
        end
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        firstClk = cyc + 6;
        pickCpu();
    endtask

    initial begin
        logic [AW-1:0] rAddr;
        logic [7:0]    oldVal;
        logic [7:0]    newVal;
        repeat (3) applyStimulus();
        checkOutput("rst_wen", 32'(ram_w_en), 32'd0);
        releaseReset();

        // Request raised before the first CPU enable must wait for phase_ok.
        issueDma(1'b1, AW'(13'h1FFF), 8'h3C);
        checkOutput("first_ack_pred", 32'(pred - firstClk), 32'd3);
        waitDone();
        applyStimulus();
        issueDma(1'b0, AW'(13'h1FFF), 8'h00);
        waitDone();
        checkOutput("dma_rd_1fff", 32'(dma_dout), 32'h3C);

        runOps(150);

        // Reset landing on the access cycle of a DMA write.
        waitPhase(5);
        rAddr  = pickAddr();
        oldVal = shadow[rAddr];
        newVal = ~oldVal;
        issueDma(1'b1, rAddr, newVal);
        for (int w = 0; w < PER && cyc < pred - 1; w++) applyStimulus();
        rst = 1'b1;
        cpu_clken = 1'b0;
        firstClk = BIG;
        pending = 1'b0;
        dma_req = 1'b0;
        #1;
        checkOutput("rst_mid_ack", 32'(dma_ack), 32'd0);
        checkOutput("rst_mid_dout", 32'(dma_dout), 32'h00);
        lastDout = 8'h00;
        repeat (2) applyStimulus();
        checkOutput("rst_mem_intact", 32'((mem[rAddr] == oldVal) || (mem[rAddr] == newVal)), 32'd1);
        shadow[rAddr] = mem[rAddr];
        releaseReset();

        issueDma(1'b0, rAddr, 8'h00);
        waitDone();
        runOps(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
